// File: rtl/l1_writeback_sender.sv
// L1-side write-back transmitter: queues dirty lines and replays them to L2
// as single-cycle flush strobes, throttled by l2_busy.
module l1_writeback_sender #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       evict_valid,
   input  logic [ADDR_W-1:0]          evict_address,
   input  logic [DATA_W-1:0]          evict_data,
   output logic                       evict_ready,
   input  logic                       l2_busy,
   output logic                       flush,
   output logic [ADDR_W-1:0]          bus_address_out,
   output logic [DATA_W-1:0]          bus_data_out,
   output logic [TAG_W-1:0]           bus_tag_out,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       queue_empty,
   output logic                       overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t state;
   state_t state_nx;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] last;
   logic          pop;
   logic          push;
   logic          coalesce;
   logic          full;
   logic          nonempty;

   assign last     = tail - PW'(1);
   assign full     = (fifo_count == CW'(DEPTH));
   assign nonempty = (fifo_count != '0);

   // The tail entry is only being popped when it is also the head.
   assign coalesce = evict_valid && nonempty
                  && (evict_address == addr_q[last])
                  && !(pop && fifo_count == CW'(1));

   assign evict_ready = !full || coalesce;
   assign push        = evict_valid && evict_ready && !coalesce;
   assign queue_empty = !nonempty && (state == IDLE);

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      unique case (state)
         IDLE, GAP: begin
            if (nonempty && !l2_busy) begin
               pop      = 1'b1;
               state_nx = SEND;
            end else begin
               state_nx = IDLE;
            end
         end
         SEND:    state_nx = GAP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head            <= '0;
         tail            <= '0;
         fifo_count      <= '0;
         flush           <= 1'b0;
         bus_address_out <= '0;
         bus_data_out    <= '0;
         bus_tag_out     <= '0;
         overflow_err    <= 1'b0;
      end else begin
         flush <= pop;
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head            <= head + PW'(1);
            bus_address_out <= addr_q[head];
            bus_data_out    <= data_q[head];
            bus_tag_out     <= {addr_q[head][ADDR_W-1 -: TAG_W-1], 1'b1};
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + CW'(1);
         end else if (pop && !push) begin
            fifo_count <= fifo_count - CW'(1);
         end
         if (evict_valid && !evict_ready) begin
            overflow_err <= 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only read once counted as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= evict_address;
         data_q[tail] <= evict_data;
      end else if (coalesce) begin
         data_q[last] <= evict_data;
      end
   end

endmodule
